// File: rtl/debug_cmd_rx_pkg.sv
// rtl/debug_cmd_rx_pkg.sv - shared opcodes, FSM state types and bit-timing helper
package debug_cmd_rx_pkg;

    localparam logic [7:0] OP_HALT   = 8'h48;
    localparam logic [7:0] OP_STEP   = 8'h53;
    localparam logic [7:0] OP_RESET  = 8'h52;
    localparam logic [7:0] OP_BP_SET = 8'h42;
    localparam logic [7:0] OP_BP_CLR = 8'h43;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        P_CMD    = 2'd0,
        P_ARG_HI = 2'd1,
        P_ARG_LO = 2'd2
    } parse_state_t;

    // Bits shorter than 4 clocks leave no room for a mid-bit sample point.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        int c;
        c = clk_hz / baud;
        return (c < 4) ? 4 : c;
    endfunction

endpackage

// File: rtl/debug_cmd_rx_if.sv
// rtl/debug_cmd_rx_if.sv - received-byte and debug-command outputs of debug_cmd_rx
interface debug_cmd_rx_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err;
    logic        halt_toggle;
    logic        step;
    logic        gb_reset;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic        cmd_err;

    modport master (
        output byte_valid, byte_data, frame_err,
        output halt_toggle, step, gb_reset, bp_en, bp_addr, cmd_err
    );

    modport slave (
        input byte_valid, byte_data, frame_err,
        input halt_toggle, step, gb_reset, bp_en, bp_addr, cmd_err
    );
endinterface

// File: rtl/debug_cmd_rx_uart_rx_byte.sv
// rtl/debug_cmd_rx_uart_rx_byte.sv - 8N1 UART byte receiver with synchronizer and frame check
module uart_rx_byte
    import debug_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RX_IDLE;
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                    if (!rx_sync)
                        state <= RX_START;
                end
                // Half-bit check rejects short low glitches before committing to a frame.
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                            state      <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // A low stop bit may be a break; wait for the line to recover.
                RX_WAIT_IDLE: begin
                    if (rx_sync)
                        state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_cmd_rx.sv
// rtl/debug_cmd_rx.sv - UART debug command receiver: byte receiver plus opcode/argument parser
module debug_cmd_rx
    import debug_cmd_rx_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    debug_cmd_rx_if.master dbg
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         rx_ferr;

    parse_state_t pstate;
    logic [7:0]   arg_hi;
    logic [15:0]  bp_addr_q;
    logic         bp_en_q;
    logic         halt_q;
    logic         step_q;
    logic         gb_reset_q;
    logic         cmd_err_q;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(rx_valid),
        .byte_data (rx_data),
        .frame_err (rx_ferr)
    );

    // Only one event arrives per cycle, so at most one command pulse can fire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pstate     <= P_CMD;
            arg_hi     <= 8'h00;
            bp_addr_q  <= 16'h0000;
            bp_en_q    <= 1'b0;
            halt_q     <= 1'b0;
            step_q     <= 1'b0;
            gb_reset_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            halt_q     <= 1'b0;
            step_q     <= 1'b0;
            gb_reset_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            if (rx_valid) begin
                case (pstate)
                    P_CMD: begin
                        case (rx_data)
                            OP_HALT:   halt_q     <= 1'b1;
                            OP_STEP:   step_q     <= 1'b1;
                            OP_RESET:  gb_reset_q <= 1'b1;
                            OP_BP_CLR: bp_en_q    <= 1'b0;
                            OP_BP_SET: pstate     <= P_ARG_HI;
                            default:   cmd_err_q  <= 1'b1;
                        endcase
                    end
                    P_ARG_HI: begin
                        arg_hi <= rx_data;
                        pstate <= P_ARG_LO;
                    end
                    P_ARG_LO: begin
                        bp_addr_q <= {arg_hi, rx_data};
                        bp_en_q   <= 1'b1;
                        pstate    <= P_CMD;
                    end
                    default: pstate <= P_CMD;
                endcase
            end else if (rx_ferr && pstate != P_CMD) begin
                // A corrupted argument byte abandons the half-built breakpoint.
                cmd_err_q <= 1'b1;
                pstate    <= P_CMD;
            end
        end
    end

    assign dbg.byte_valid  = rx_valid;
    assign dbg.byte_data   = rx_data;
    assign dbg.frame_err   = rx_ferr;
    assign dbg.halt_toggle = halt_q;
    assign dbg.step        = step_q;
    assign dbg.gb_reset    = gb_reset_q;
    assign dbg.bp_en       = bp_en_q;
    assign dbg.bp_addr     = bp_addr_q;
    assign dbg.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_debug_cmd_rx.sv
// tb/tb_debug_cmd_rx.sv - randomized self-checking bench for debug_cmd_rx against a command-level model
module tb_debug_cmd_rx;

    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;

    debug_cmd_rx_if dbg ();

    debug_cmd_rx #(
        .CLK_HZ(1000000),
        .BAUD  (100000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (rx),
        .dbg(dbg)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Cumulative event counters sampled on the falling edge.
    int cyc = 0;
    int n_bv = 0, n_fe = 0, n_halt = 0, n_step = 0, n_gbr = 0, n_cerr = 0, n_multi = 0;
    int last_bv_cyc = 0, last_fe_cyc = 0, last_cmd_cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dbg.byte_valid) begin n_bv <= n_bv + 1; last_bv_cyc <= cyc; end
        if (dbg.frame_err)  begin n_fe <= n_fe + 1; last_fe_cyc <= cyc; end
        if (dbg.halt_toggle) n_halt <= n_halt + 1;
        if (dbg.step)        n_step <= n_step + 1;
        if (dbg.gb_reset)    n_gbr  <= n_gbr + 1;
        if (dbg.cmd_err)     n_cerr <= n_cerr + 1;
        if (dbg.halt_toggle | dbg.step | dbg.gb_reset | dbg.cmd_err) last_cmd_cyc <= cyc;
        if (32'(dbg.halt_toggle) + 32'(dbg.step) + 32'(dbg.gb_reset) + 32'(dbg.cmd_err) > 1)
            n_multi <= n_multi + 1;
    end

    // Command-level reference: how many argument bytes are still owed, and the breakpoint.
    int          m_args_owed = 0;
    logic [7:0]  m_hi = 8'h00;
    logic        m_bp_en = 1'b0;
    logic [15:0] m_bp_addr = 16'h0000;
    logic [7:0]  m_bdata = 8'h00;

    // Returns 0 none, 1 halt, 2 step, 3 reset, 4 cmd_err.
    function automatic int model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            if (m_args_owed != 0) begin m_args_owed = 0; return 4; end
            return 0;
        end
        m_bdata = b;
        if (m_args_owed == 2) begin m_hi = b; m_args_owed = 1; return 0; end
        if (m_args_owed == 1) begin
            m_bp_addr = {m_hi, b}; m_bp_en = 1'b1; m_args_owed = 0; return 0;
        end
        if (b == "H") return 1;
        if (b == "S") return 2;
        if (b == "R") return 3;
        if (b == "C") begin m_bp_en = 1'b0; return 0; end
        if (b == "B") begin m_args_owed = 2; return 0; end
        return 4;
    endfunction

    task automatic model_reset();
        m_args_owed = 0; m_hi = 8'h00; m_bp_en = 1'b0; m_bp_addr = 16'h0000; m_bdata = 8'h00;
    endtask

    task automatic bit_period(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit ok);
        @(posedge clk); #1;
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(b[i]);
        bit_period(ok);
        rx = 1'b1;
        repeat (25) @(posedge clk);
        #1;
    endtask

    task automatic test_byte(input logic [7:0] b, input bit ok);
        int s_bv, s_fe, s_h, s_s, s_r, s_c, s_m, kind, ref_cyc;
        int eh, es, er, ec;
        s_bv = n_bv; s_fe = n_fe; s_h = n_halt; s_s = n_step; s_r = n_gbr; s_c = n_cerr; s_m = n_multi;
        kind = model_byte(b, ok);
        send_frame(b, ok);
        eh = (kind == 1) ? 1 : 0; es = (kind == 2) ? 1 : 0;
        er = (kind == 3) ? 1 : 0; ec = (kind == 4) ? 1 : 0;
        checks++;
        if (n_bv - s_bv !== (ok ? 1 : 0) || n_fe - s_fe !== (ok ? 0 : 1)) begin
            failures++;
            $display("FAIL rx_events byte=%h ok=%0d got bv=%0d fe=%0d", b, ok, n_bv - s_bv, n_fe - s_fe);
        end
        checks++;
        if (n_halt - s_h !== eh || n_step - s_s !== es || n_gbr - s_r !== er || n_cerr - s_c !== ec) begin
            failures++;
            $display("FAIL cmd_pulses byte=%h ok=%0d got h/s/r/e=%0d%0d%0d%0d want %0d%0d%0d%0d",
                     b, ok, n_halt - s_h, n_step - s_s, n_gbr - s_r, n_cerr - s_c, eh, es, er, ec);
        end
        checks++;
        if (dbg.byte_data !== m_bdata || dbg.bp_en !== m_bp_en || dbg.bp_addr !== m_bp_addr) begin
            failures++;
            $display("FAIL levels byte=%h got data=%h en=%0d addr=%h want data=%h en=%0d addr=%h",
                     b, dbg.byte_data, dbg.bp_en, dbg.bp_addr, m_bdata, m_bp_en, m_bp_addr);
        end
        checks++;
        if (n_multi !== s_m) begin
            failures++;
            $display("FAIL pulse_exclusive byte=%h got %0d overlapping cycles want 0", b, n_multi - s_m);
        end
        if (kind != 0) begin
            ref_cyc = ok ? last_bv_cyc : last_fe_cyc;
            checks++;
            if (last_cmd_cyc - ref_cyc !== 1) begin
                failures++;
                $display("FAIL latency byte=%h got %0d want 1", b, last_cmd_cyc - ref_cyc);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({dbg.byte_valid, dbg.frame_err, dbg.halt_toggle, dbg.step, dbg.gb_reset, dbg.cmd_err,
             dbg.bp_en, dbg.byte_data, dbg.bp_addr} !== 31'h0) begin
            failures++;
            $display("FAIL reset_state got data=%h addr=%h en=%0d pulses=%b want all zero", dbg.byte_data,
                     dbg.bp_addr, dbg.bp_en, {dbg.byte_valid, dbg.frame_err, dbg.halt_toggle, dbg.step,
                     dbg.gb_reset, dbg.cmd_err});
        end
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_halt();
        test_byte(8'h48, 1'b1);
    endtask

    task automatic test_breakpoint();
        test_byte(8'h42, 1'b1);
        test_byte(8'h01, 1'b1);
        test_byte(8'h50, 1'b1);
        test_byte(8'h43, 1'b1);
        checks++;
        if (dbg.bp_addr !== 16'h0150 || dbg.bp_en !== 1'b0) begin
            failures++;
            $display("FAIL bp_clear got en=%0d addr=%h want en=0 addr=0150", dbg.bp_en, dbg.bp_addr);
        end
    endtask

    task automatic test_frame_err();
        test_byte(8'h53, 1'b0);
        test_byte(8'h53, 1'b1);
    endtask

    task automatic test_glitch();
        int s_bv, s_fe;
        s_bv = n_bv; s_fe = n_fe;
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (n_bv !== s_bv || n_fe !== s_fe) begin
            failures++;
            $display("FAIL glitch got bv=%0d fe=%0d want 0 0", n_bv - s_bv, n_fe - s_fe);
        end
        test_byte(8'h52, 1'b1);
    endtask

    task automatic test_arg_abort();
        test_byte(8'h42, 1'b1);
        test_byte(8'h12, 1'b1);
        test_byte(8'h34, 1'b0);
        test_byte(8'h7F, 1'b1);
    endtask

    task automatic test_arg_literal();
        test_byte(8'h42, 1'b1);
        test_byte(8'h48, 1'b1);
        test_byte(8'h53, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int s_all;
        b = 8'h42;
        test_byte(8'h42, 1'b1);
        s_all = n_bv + n_fe + n_halt + n_step + n_gbr + n_cerr;
        @(posedge clk); #1;
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(b[i]);
        rx = b[4];
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0; rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (dbg.bp_en !== 1'b0 || dbg.bp_addr !== 16'h0000 || dbg.byte_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_levels got en=%0d addr=%h data=%h want 0 0000 00",
                     dbg.bp_en, dbg.bp_addr, dbg.byte_data);
        end
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (n_bv + n_fe + n_halt + n_step + n_gbr + n_cerr !== s_all) begin
            failures++;
            $display("FAIL reset_mid_pulses got %0d pulses want 0",
                     n_bv + n_fe + n_halt + n_step + n_gbr + n_cerr - s_all);
        end
        test_byte(8'h48, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] pool [6];
        logic [7:0] b;
        bit ok;
        pool[0] = 8'h48; pool[1] = 8'h53; pool[2] = 8'h52;
        pool[3] = 8'h43; pool[4] = 8'h42; pool[5] = 8'h42;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, 5)];
            ok = ($urandom_range(0, 7) != 0);
            test_byte(b, ok);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_halt();
        test_breakpoint();
        test_frame_err();
        test_glitch();
        test_arg_abort();
        test_arg_literal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
